// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: bit-period math, 8N1 frame constants and the
// transmitter FSM state encoding.
package uart_tx_fifo_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK,
    ST_MARK
  } tx_state_t;

  function automatic int calc_div(input int clk_freq, input int bit_freq);
    return clk_freq / bit_freq;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Fabric-side handshake of the buffered UART transmitter.
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16
);
  logic                   wr;
  logic [DATA_BITS-1:0]   din;
  logic                   brk;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;

  modport master (output wr, din, brk, input full, count, busy);
  modport slave  (input wr, din, brk, output full, count, busy);
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered full/count and a registered read port,
// so the storage array maps onto block RAM.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic [WIDTH-1:0]       din,
  input  logic                   rd,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_reg;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             full_reg;
  logic             wr_en, rd_en;

  // A write into a full FIFO is dropped even when a pop frees a slot this cycle.
  assign wr_en = wr && !full_reg;
  assign rd_en = rd && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (wr_en && !rd_en)
      count_next = count_reg + (AW+1)'(1);
    else if (rd_en && !wr_en)
      count_next = count_reg - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= din;
    if (rd_en)
      dout_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_CNT);
    end
  end

  assign dout  = dout_reg;
  assign full  = full_reg;
  assign count = count_reg;
  assign empty = (count_reg == '0);
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: queued octets go out back-to-back, and a
// break request inserts BREAK_BITS of low line followed by one mark bit.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 48_000_000,
  parameter int BIT_FREQ   = 115_200,
  parameter int DEPTH      = 16,
  parameter int BREAK_BITS = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus,
  output logic          tx
);
  localparam int DIV   = calc_div(CLK_FREQ, BIT_FREQ);
  localparam int DIV_W = cnt_width(DIV);
  localparam int BRK_W = cnt_width(BREAK_BITS);
  localparam int IDX_W = cnt_width(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BREAK_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_t              state_reg, state_next;
  logic [DIV_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [IDX_W-1:0]       bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [BRK_W-1:0]       brk_cnt_reg, brk_cnt_next;
  logic                   pend_reg, pend_next;
  logic                   tx_reg, tx_next;
  logic                   bit_end, pop, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_dout;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (bus.wr),
    .din   (bus.din),
    .rd    (pop),
    .dout  (fifo_dout),
    .full  (bus.full),
    .empty (fifo_empty),
    .count (bus.count)
  );

  assign bit_end  = (bit_cnt_reg == DIV_LAST);
  assign bus.busy = (state_reg != ST_IDLE) || !fifo_empty || pend_reg;

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    brk_cnt_next = brk_cnt_reg;
    pend_next    = pend_reg;
    pop          = 1'b0;
    tx_next      = STOP_BIT;

    // Every state change lands on a bit boundary, so the counter wraps to 0 then.
    if (state_reg != ST_IDLE)
      bit_cnt_next = bit_end ? '0 : bit_cnt_reg + DIV_W'(1);

    if (bus.brk && !pend_reg && state_reg != ST_BREAK && state_reg != ST_MARK)
      pend_next = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (pend_reg) begin
          state_next   = ST_BREAK;
          pend_next    = 1'b0;
          brk_cnt_next = '0;
        end else if (!fifo_empty) begin
          state_next = ST_START;
          pop        = 1'b1;
        end
      end
      ST_START: begin
        // The popped octet is on the registered FIFO output by the end of START.
        if (bit_end) begin
          state_next   = ST_DATA;
          shift_next   = fifo_dout;
          bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == IDX_LAST)
            state_next = ST_STOP;
          else
            bit_idx_next = bit_idx_reg + IDX_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (pend_reg) begin
            state_next   = ST_BREAK;
            pend_next    = 1'b0;
            brk_cnt_next = '0;
          end else if (!fifo_empty) begin
            state_next = ST_START;
            pop        = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        if (bit_end) begin
          if (brk_cnt_reg == BRK_LAST)
            state_next = ST_MARK;
          else
            brk_cnt_next = brk_cnt_reg + BRK_W'(1);
        end
      end
      ST_MARK: begin
        if (bit_end)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // tx is registered from the next state so the pin never glitches.
    case (state_next)
      ST_START: tx_next = START_BIT;
      ST_DATA:  tx_next = shift_next[0];
      ST_BREAK: tx_next = 1'b0;
      default:  tx_next = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      brk_cnt_reg <= '0;
      pend_reg    <= 1'b0;
      tx_reg      <= STOP_BIT;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      brk_cnt_reg <= brk_cnt_next;
      pend_reg    <= pend_next;
      tx_reg      <= tx_next;
    end
  end

  assign tx = tx_reg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=10: a line monitor decodes frames
// from tx and each scenario compares against hand-derived cycle numbers.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(16)) bus ();

  uart_tx_fifo #(
    .CLK_FREQ   (1_000_000),
    .BIT_FREQ   (100_000),
    .DEPTH      (16),
    .BREAK_BITS (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tx    (tx)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t     frames[$];
  int         mon_mode = 0;
  int         mon_s = 0;
  logic [7:0] mon_d = '0;

  // Line monitor: samples mid-bit; a low stop bit means a break, not a frame.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_mode <= 0;
    end else begin
      case (mon_mode)
        0: if (tx == 1'b0) begin
          mon_mode <= 1;
          mon_s    <= cyc;
        end
        1: begin
          if ((cyc - mon_s) == 5 && tx != 1'b0)
            mon_mode <= 0;
          else if ((cyc - mon_s) >= 15 && (cyc - mon_s) <= 85 && ((cyc - mon_s) % 10) == 5)
            mon_d[((cyc - mon_s) - 15) / 10] <= tx;
          else if ((cyc - mon_s) == 95) begin
            if (tx == 1'b1) begin
              frames.push_back('{mon_d, mon_s});
              $display("frame data=0x%02h start=%0d", mon_d, mon_s);
              mon_mode <= 0;
            end else begin
              mon_mode <= 2;
            end
          end
        end
        default: if (tx == 1'b1) mon_mode <= 0;
      endcase
    end
  end

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int c);
    int n = 0;
    while (cyc < c && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic write(input logic [7:0] d);
    bus.wr  = 1'b1;
    bus.din = d;
    tick();
    bus.wr  = 1'b0;
  endtask

  task automatic run_len(input logic lvl, input int limit, output int n);
    n = 0;
    while (tx == lvl && n < limit) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle(input string tag, input int limit, output int done);
    int n = 0;
    while (bus.busy && n < limit) begin
      tick();
      n++;
    end
    check(tag, bus.busy, 1'b0);
    done = cyc;
  endtask

  // Expected tx for a 0x55 frame written at relative cycle 0.
  function automatic logic exp_tx55(input int k);
    logic [7:0] d;
    d = 8'h55;
    if (k < 2)   return 1'b1;
    if (k < 12)  return 1'b0;
    if (k < 92)  return d[(k - 12) / 10];
    return 1'b1;
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, base, done, lo, hi, d;

    bus.wr  = 1'b0;
    bus.din = '0;
    bus.brk = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_full", bus.full, 1'b0);
    check("rst_count", bus.count, 0);
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_tx", tx, 1'b1);
    check("post_rst_busy", bus.busy, 1'b0);

    // Single 0x55 frame, cycle-exact
    base = frames.size();
    c0 = cyc;
    write(8'h55);
    for (int k = 1; k <= 102; k++) begin
      check("t1_tx", tx, exp_tx55(k));
      if (k == 1) begin
        check("t1_count", bus.count, 1);
        check("t1_busy_rise", bus.busy, 1'b1);
      end
      if (k == 101) check("t1_busy_stop", bus.busy, 1'b1);
      if (k == 102) check("t1_busy_fall", bus.busy, 1'b0);
      if (k < 102) tick();
    end
    check("t1_nframes", frames.size() - base, 1);
    if (frames.size() > base) begin
      check("t1_data", frames[base].data, 8'h55);
      check("t1_start", frames[base].start - c0, 2);
    end
    $display("scenario single 0x55 done at cycle %0d", cyc);

    // 20 writes: 16 fill the FIFO while 0x00 is in flight, 0x11..0x13 drop
    tick_to(cyc + 5);
    base = frames.size();
    c0 = cyc;
    for (int j = 0; j < 20; j++) begin
      if (j == 16) begin
        check("t2_count15", bus.count, 15);
        check("t2_notfull", bus.full, 1'b0);
      end
      if (j == 17) begin
        check("t2_count16", bus.count, 16);
        check("t2_full", bus.full, 1'b1);
      end
      write(8'(j));
    end
    check("t2_count_hold", bus.count, 16);
    check("t2_full_hold", bus.full, 1'b1);
    wait_idle("t2_idle", 2500, done);
    check("t2_nframes", frames.size() - base, 17);
    for (int i = 0; i < 17 && base + i < frames.size(); i++) begin
      check("t2_data", frames[base + i].data, 8'(i));
      check("t2_start", frames[base + i].start - c0, 2 + 100 * i);
    end
    check("t2_duration", done - c0, 2 + 1700);
    $display("scenario burst of 20 done at cycle %0d", cyc);

    // Break requested mid-frame of 0xA3 with 0x3C queued
    tick_to(cyc + 5);
    base = frames.size();
    c0 = cyc;
    write(8'hA3);
    write(8'h3C);
    tick_to(c0 + 40);
    bus.brk = 1'b1;
    tick();
    bus.brk = 1'b0;
    tick_to(c0 + 102);
    run_len(1'b0, 400, lo);
    check("t3_break_len", lo, 200);
    run_len(1'b1, 50, hi);
    check("t3_mark_len_ok", (hi >= 10 && hi <= 11), 1'b1);
    wait_idle("t3_idle", 500, done);
    check("t3_nframes", frames.size() - base, 2);
    if (frames.size() >= base + 2) begin
      check("t3_first", frames[base].data, 8'hA3);
      check("t3_first_start", frames[base].start - c0, 2);
      check("t3_second", frames[base + 1].data, 8'h3C);
      d = frames[base + 1].start - c0;
      check("t3_second_start_ok", (d == 312 || d == 313), 1'b1);
    end
    $display("scenario break mid-frame done at cycle %0d", cyc);

    // Full FIFO, write coinciding with a pop is dropped
    tick_to(cyc + 5);
    base = frames.size();
    c0 = cyc;
    for (int j = 0; j < 17; j++)
      write(8'h80 + 8'(j));
    tick_to(c0 + 101);
    check("t4_count_full", bus.count, 16);
    check("t4_full", bus.full, 1'b1);
    bus.wr  = 1'b1;
    bus.din = 8'hEE;
    tick();
    bus.wr  = 1'b0;
    check("t4_count_after_pop", bus.count, 15);
    check("t4_full_clear", bus.full, 1'b0);
    wait_idle("t4_idle", 2000, done);
    check("t4_nframes", frames.size() - base, 17);
    for (int i = 0; i < 17 && base + i < frames.size(); i++)
      check("t4_data", frames[base + i].data, 8'h80 + 8'(i));
    check("t4_count_end", bus.count, 0);
    $display("scenario full plus pop done at cycle %0d", cyc);

    // Reset during the data bits of 0xFF with 5 octets queued
    tick_to(cyc + 5);
    base = frames.size();
    c0 = cyc;
    write(8'hFF);
    for (int j = 1; j <= 5; j++)
      write(8'h10 + 8'(j));
    tick_to(c0 + 30);
    check("t5_busy_before", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_tx_async", tx, 1'b1);
    check("t5_count_async", bus.count, 0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    check("t5_count", bus.count, 0);
    check("t5_busy", bus.busy, 1'b0);
    check("t5_full", bus.full, 1'b0);
    lo = 0;
    repeat (300) begin
      if (tx == 1'b0) lo++;
      tick();
    end
    check("t5_quiet_lows", lo, 0);
    check("t5_nframes", frames.size() - base, 0);
    $display("scenario reset mid-frame done at cycle %0d", cyc);

    // Two break pulses 50 cycles apart give one break
    base = frames.size();
    c0 = cyc;
    bus.brk = 1'b1;
    tick();
    bus.brk = 1'b0;
    lo = 0;
    d = -1;
    repeat (400) begin
      bus.brk = (cyc == c0 + 50);
      if (tx == 1'b0) begin
        lo++;
        if (d < 0) d = cyc - c0;
      end
      tick();
    end
    bus.brk = 1'b0;
    check("t6_break_len", lo, 200);
    check("t6_break_start", d, 2);
    check("t6_busy_end", bus.busy, 1'b0);
    check("t6_nframes", frames.size() - base, 0);
    $display("scenario double break done at cycle %0d", cyc);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
